qick_vec2bit_pulse: RTL and testbench
=====================================

// Module: qick_vec2bit_pulse
// PURPOSE
//  Parametrised, registered vector-to-bit splitter. Breaks an IN_DW-bit control word into
//  OUT_QTY single-bit outputs on a packed bus. Each output is either a level follower or a
//  retriggerable one-shot pulse of programmable length. Sits between tProcessor port
//  registers and per-channel trigger/marker lines.
// PARAMETERS
//  IN_DW    16  width of din; OUT_QTY <= IN_DW, upper din bits are ignored
//  OUT_QTY  16  number of output channels (1..IN_DW)
//  CNT_DW    8  width of pulse-length counter / len_i
// PORTS
//  clk_i    in   1        single clock; all logic rising-edge
//  rst_ni   in   1        reset, synchronous, active-low
//  din      in   IN_DW    input vector; bit k drives channel k
//  mode_i   in   OUT_QTY  per-channel mode: 0 = level, 1 = pulse
//  len_i    in   CNT_DW   pulse length in clk_i cycles, shared by all channels
//  mask_i   in   OUT_QTY  per-channel enable; 0 forces channel off
//  dout     out  OUT_QTY  registered channel outputs
//  busy_o   out  OUT_QTY  1 while channel k is in PULSE state
// BEHAVIOUR
//  - Reset (rst_ni=0 at clk_i edge):
//    dout=0, busy_o=0, all counters=0, all states=IDLE, edge-history samples=0.
//  - Sample stage: s[k] = din[k] registered each cycle; p[k] = previous s[k].
//    Rising edge: rise[k] = s[k] & ~p[k].
//    Because p resets to 0, a din bit held high through reset release produces one rise.
//  - Level mode (mode_i[k]=0): dout[k] <= s[k] & mask_i[k].
//    Latency din->dout is 2 clk_i edges. busy_o[k]=0.
//  - Pulse mode (mode_i[k]=1), per-channel FSM:
//    IDLE : on rise[k] & mask_i[k] -> PULSE.
//           cnt <= max(len_i,1); dout[k] <= 1; busy_o[k] <= 1.
//    PULSE: cnt decrements each cycle. dout[k] stays high exactly max(len_i,1) cycles,
//           then IDLE with dout[k] <= 0, busy_o[k] <= 0.
//           A rise[k] during PULSE (including on the final cycle) reloads cnt from the
//           current len_i: retrigger extends the pulse, with no low gap.
//  - len_i is sampled only at trigger/retrigger. Changes mid-pulse do not affect a
//    running pulse. len_i=0 behaves as 1.
//  - mask_i[k]=0: channel goes to IDLE, cnt=0, dout[k]=0 on the next edge.
//    Edge history still updates, so no rise is generated merely by re-enabling the mask.
//  - mode_i[k] change mid-pulse: the pulse is aborted (IDLE, cnt=0).
//    The channel follows the new mode from the next edge.
//  - Channels are fully independent. Simultaneous rises on many channels are all honoured.
//  - Counter never wraps: cnt saturates at 0 in IDLE.
// CONFIGURATION
//  VEC2BIT_SYNC_EN defined:
//    din passes through a 2-flop synchroniser (reset 0) ahead of the sample stage,
//    for asynchronous sources. Latency +2 cycles (level mode din->dout = 4 edges).
//    Both synchroniser flops clear on reset.
//  VEC2BIT_SYNC_EN undefined:
//    No synchroniser; din must be synchronous to clk_i. Latencies as above.
// TESTING
//  1) Reset: rst_ni=0 for 3 cycles with din=16'hFFFF -> dout=0, busy_o=0 throughout.
//  2) Level: mode_i=0, mask_i=16'hFFFF, din=16'hA5A5 -> dout=16'hA5A5 2 edges later;
//     with mask_i=16'h00FF -> dout=16'h00A5.
//  3) Pulse: mode_i[3]=1, len_i=5, din[3] 0->1 held high ->
//     dout[3] high exactly 5 cycles, busy_o[3] mirrors it, then 0 despite din[3] still high.
//  4) Retrigger: len_i=4, din[3] toggles 0->1 at t0, 1->0 at t0+1, 0->1 at t0+2 ->
//     dout[3] high continuously for 6 cycles. Also len_i=0 -> 1-cycle pulse.
//  5) Abort: mid-pulse drop mask_i[3] -> dout[3]=0 next edge, no pulse after re-enable
//     while din[3] held high. Mid-pulse set mode_i[3]=0 -> dout[3] follows din[3].
//  6) Reset mid-pulse: rst_ni=0 during an active 200-cycle pulse ->
//     dout/busy_o=0 next edge; rerun 2) with VEC2BIT_SYNC_EN defined -> latency 4 edges.

Source files
------------

// File: rtl/qick_vec2bit_pulse_if.sv
// Bundles the control vector inputs and per-channel outputs of the vec2bit splitter.
// The splitter is the slave; the tProcessor-side driver is the master.
interface qick_vec2bit_pulse_if #(
    parameter int IN_DW   = 16,
    parameter int OUT_QTY = 16,
    parameter int CNT_DW  = 8
);
    logic [IN_DW-1:0]   din;
    logic [OUT_QTY-1:0] mode_i;
    logic [CNT_DW-1:0]  len_i;
    logic [OUT_QTY-1:0] mask_i;
    logic [OUT_QTY-1:0] dout;
    logic [OUT_QTY-1:0] busy_o;

    modport master (output din, mode_i, len_i, mask_i, input dout, busy_o);
    modport slave  (input din, mode_i, len_i, mask_i, output dout, busy_o);
endinterface

// File: rtl/qick_vec2bit_pulse.sv
// Vector-to-bit splitter: each channel is a level follower or a retriggerable one-shot pulse.
// Latency din->dout 2 edges (4 with VEC2BIT_SYNC_EN, which adds a 2-flop din synchroniser).
// No backpressure: outputs update every cycle, inputs are never stalled.
module qick_vec2bit_pulse #(
    parameter int IN_DW   = 16,
    parameter int OUT_QTY = 16,
    parameter int CNT_DW  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    qick_vec2bit_pulse_if.slave   bus
);

    typedef enum logic {IDLE = 1'b0, PULSE = 1'b1} state_t;

    logic [OUT_QTY-1:0] din_in;

`ifdef VEC2BIT_SYNC_EN
    logic [OUT_QTY-1:0] sync1, sync2;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.din[OUT_QTY-1:0];
            sync2 <= sync1;
        end
    end

    assign din_in = sync2;
`else
    assign din_in = bus.din[OUT_QTY-1:0];
`endif

    logic [OUT_QTY-1:0] s_q, p_q, rise;
    logic [OUT_QTY-1:0] dout_q, dout_d, busy;
    logic [CNT_DW-1:0]  len_eff;
    state_t             state_q [OUT_QTY];
    state_t             state_d [OUT_QTY];
    logic [CNT_DW-1:0]  cnt_q   [OUT_QTY];
    logic [CNT_DW-1:0]  cnt_d   [OUT_QTY];

    assign rise    = s_q & ~p_q;
    assign len_eff = (bus.len_i == '0) ? CNT_DW'(1) : bus.len_i;

    always_comb begin
        for (int k = 0; k < OUT_QTY; k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            dout_d[k]  = dout_q[k];
            if (!bus.mask_i[k]) begin
                state_d[k] = IDLE;
                cnt_d[k]   = '0;
                dout_d[k]  = 1'b0;
            end else if (!bus.mode_i[k]) begin
                // Level mode also aborts any pulse left over from a mode switch.
                state_d[k] = IDLE;
                cnt_d[k]   = '0;
                dout_d[k]  = s_q[k];
            end else begin
                case (state_q[k])
                    IDLE: begin
                        cnt_d[k]  = '0;
                        dout_d[k] = 1'b0;
                        if (rise[k]) begin
                            state_d[k] = PULSE;
                            cnt_d[k]   = len_eff;
                            dout_d[k]  = 1'b1;
                        end
                    end
                    PULSE: begin
                        dout_d[k] = 1'b1;
                        if (rise[k]) begin
                            cnt_d[k] = len_eff;
                        end else if (cnt_q[k] <= CNT_DW'(1)) begin
                            state_d[k] = IDLE;
                            cnt_d[k]   = '0;
                            dout_d[k]  = 1'b0;
                        end else begin
                            cnt_d[k] = cnt_q[k] - CNT_DW'(1);
                        end
                    end
                    default: begin
                        state_d[k] = IDLE;
                        cnt_d[k]   = '0;
                        dout_d[k]  = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s_q    <= '0;
            p_q    <= '0;
            dout_q <= '0;
            for (int k = 0; k < OUT_QTY; k++) begin
                state_q[k] <= IDLE;
                cnt_q[k]   <= '0;
            end
        end else begin
            s_q    <= din_in;
            p_q    <= s_q;
            dout_q <= dout_d;
            for (int k = 0; k < OUT_QTY; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int k = 0; k < OUT_QTY; k++) begin
            busy[k] = (state_q[k] == PULSE);
        end
    end

    assign bus.dout   = dout_q;
    assign bus.busy_o = busy;

endmodule

// File: tb/tb_qick_vec2bit_pulse.sv
// Self-checking bench for qick_vec2bit_pulse: level table plus hand-written pulse sequences.
module tb_qick_vec2bit_pulse;

    localparam int IN_DW   = 16;
    localparam int OUT_QTY = 16;
    localparam int CNT_DW  = 8;
`ifdef VEC2BIT_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    qick_vec2bit_pulse_if #(.IN_DW(IN_DW), .OUT_QTY(OUT_QTY), .CNT_DW(CNT_DW)) bus ();

    qick_vec2bit_pulse #(.IN_DW(IN_DW), .OUT_QTY(OUT_QTY), .CNT_DW(CNT_DW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    typedef struct {
        int          due;
        logic [15:0] dout;
        logic [15:0] busy;
        string       name;
    } exp_t;

    typedef struct {
        logic [15:0] din;
        logic [15:0] mask;
        logic [15:0] exp;
    } lvl_t;

    exp_t sbq[$];
    int   edge_cnt = 0;
    int   checks   = 0;
    int   errors   = 0;

    always @(posedge clk) edge_cnt++;

    // Compare every expectation that falls due on the edge just taken.
    always @(negedge clk) begin
        int i;
        i = 0;
        while (i < sbq.size()) begin
            if (sbq[i].due == edge_cnt) begin
                checks++;
                if (bus.dout !== sbq[i].dout || bus.busy_o !== sbq[i].busy) begin
                    errors++;
                    $display("FAIL %s @edge %0d: dout=%h busy=%h, want dout=%h busy=%h",
                             sbq[i].name, edge_cnt, bus.dout, bus.busy_o, sbq[i].dout, sbq[i].busy);
                end
                sbq.delete(i);
            end else if (sbq[i].due < edge_cnt) begin
                errors++;
                $display("FAIL %s: expectation for edge %0d never compared", sbq[i].name, sbq[i].due);
                sbq.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic expect_at(input int due, input logic [15:0] d, input logic [15:0] b, input string nm);
        exp_t e;
        e.due  = due;
        e.dout = d;
        e.busy = b;
        e.name = nm;
        sbq.push_back(e);
    endtask

    lvl_t lv[6];
    int   c;

    initial begin
        lv[0] = '{16'hA5A5, 16'hFFFF, 16'hA5A5};
        lv[1] = '{16'hA5A5, 16'h00FF, 16'h00A5};
        lv[2] = '{16'h5A5A, 16'hFFFF, 16'h5A5A};
        lv[3] = '{16'hFFFF, 16'hF0F0, 16'hF0F0};
        lv[4] = '{16'h0000, 16'hFFFF, 16'h0000};
        lv[5] = '{16'h1234, 16'h0FF0, 16'h0230};

        rst_n      = 1'b0;
        bus.din    = 16'hFFFF;
        bus.mode_i = '0;
        bus.mask_i = 16'hFFFF;
        bus.len_i  = '0;
        step();
        for (int i = 0; i < 3; i++) begin
            expect_at(edge_cnt, 16'h0000, 16'h0000, "reset_hold");
            step();
        end

        // din held high through release: level outputs appear after the normal latency
        rst_n = 1'b1;
        expect_at(edge_cnt + 1, 16'h0000, 16'h0000, "release_early");
        expect_at(edge_cnt + LAT, 16'hFFFF, 16'h0000, "release_level");
        idle(LAT);

        for (int i = 0; i < 6; i++) begin
            bus.din    = lv[i].din;
            bus.mask_i = lv[i].mask;
            expect_at(edge_cnt + LAT, lv[i].exp, 16'h0000, $sformatf("level%0d", i));
            idle(LAT);
        end

        // Single pulse, len 5, din held high afterwards
        bus.din = '0; bus.mask_i = 16'hFFFF; bus.mode_i = 16'h0008; bus.len_i = 8'd5;
        idle(LAT + 2);
        c = edge_cnt;
        bus.din = 16'h0008;
        expect_at(c + LAT - 1, 16'h0000, 16'h0000, "pulse_pre");
        for (int i = 0; i < 5; i++) expect_at(c + LAT + i, 16'h0008, 16'h0008, "pulse_hi");
        for (int i = 5; i < 8; i++) expect_at(c + LAT + i, 16'h0000, 16'h0000, "pulse_lo");
        idle(LAT + 9);

        // Retrigger two cycles after the first rise: 6 continuous cycles high
        bus.din = '0; bus.len_i = 8'd4;
        idle(LAT + 2);
        c = edge_cnt;
        expect_at(c + LAT - 1, 16'h0000, 16'h0000, "retrig_pre");
        for (int i = 0; i < 6; i++) expect_at(c + LAT + i, 16'h0008, 16'h0008, "retrig_hi");
        expect_at(c + LAT + 6, 16'h0000, 16'h0000, "retrig_lo");
        bus.din = 16'h0008; step();
        bus.din = 16'h0000; step();
        bus.din = 16'h0008;
        idle(LAT + 8);

        // len 0 behaves as 1
        bus.din = '0; bus.len_i = 8'd0;
        idle(LAT + 2);
        c = edge_cnt;
        bus.din = 16'h0008;
        expect_at(c + LAT - 1, 16'h0000, 16'h0000, "len0_pre");
        expect_at(c + LAT,     16'h0008, 16'h0008, "len0_hi");
        expect_at(c + LAT + 1, 16'h0000, 16'h0000, "len0_lo");
        expect_at(c + LAT + 2, 16'h0000, 16'h0000, "len0_lo2");
        idle(LAT + 4);

        // len change after trigger does not stretch the running pulse
        bus.din = '0; bus.len_i = 8'd3;
        idle(LAT + 2);
        c = edge_cnt;
        bus.din = 16'h0008;
        for (int i = 0; i < 3; i++) expect_at(c + LAT + i, 16'h0008, 16'h0008, "lenchg_hi");
        expect_at(c + LAT + 3, 16'h0000, 16'h0000, "lenchg_lo");
        expect_at(c + LAT + 4, 16'h0000, 16'h0000, "lenchg_lo2");
        idle(LAT + 1);
        bus.len_i = 8'd10;
        idle(6);

        // Mask drop mid-pulse, then re-enable with din still high
        bus.din = '0; bus.len_i = 8'd20;
        idle(LAT + 2);
        c = edge_cnt;
        bus.din = 16'h0008;
        for (int i = 0; i < 3; i++) expect_at(c + LAT + i, 16'h0008, 16'h0008, "mask_hi");
        idle(LAT + 2);
        bus.mask_i = 16'hFFF7;
        expect_at(edge_cnt + 1, 16'h0000, 16'h0000, "mask_abort");
        expect_at(edge_cnt + 2, 16'h0000, 16'h0000, "mask_off");
        idle(2);
        bus.mask_i = 16'hFFFF;
        for (int i = 1; i <= 6; i++) expect_at(edge_cnt + i, 16'h0000, 16'h0000, "mask_reenable");
        idle(7);

        // Mode switch to level mid-pulse: aborts, then follows din
        bus.din = '0;
        idle(LAT + 2);
        c = edge_cnt;
        bus.din = 16'h0008;
        for (int i = 0; i < 3; i++) expect_at(c + LAT + i, 16'h0008, 16'h0008, "mode_hi");
        idle(LAT + 2);
        bus.mode_i = 16'h0000;
        expect_at(edge_cnt + 1, 16'h0008, 16'h0000, "mode_abort");
        step();
        bus.din = 16'h0000;
        expect_at(edge_cnt + LAT - 1, 16'h0008, 16'h0000, "mode_follow_hold");
        expect_at(edge_cnt + LAT,     16'h0000, 16'h0000, "mode_follow_low");
        idle(LAT + 2);

        // All channels triggered together, some masked
        bus.mode_i = 16'hFFFF; bus.len_i = 8'd3; bus.mask_i = 16'hFF0F; bus.din = '0;
        idle(LAT + 2);
        c = edge_cnt;
        bus.din = 16'hFFFF;
        for (int i = 0; i < 3; i++) expect_at(c + LAT + i, 16'hFF0F, 16'hFF0F, "multi_hi");
        expect_at(c + LAT + 3, 16'h0000, 16'h0000, "multi_lo");
        idle(LAT + 5);

        // Reset during a long pulse
        bus.mask_i = 16'hFFFF; bus.mode_i = 16'h0008; bus.din = '0; bus.len_i = 8'd200;
        idle(LAT + 2);
        c = edge_cnt;
        bus.din = 16'h0008;
        for (int i = 0; i < 4; i++) expect_at(c + LAT + i, 16'h0008, 16'h0008, "long_hi");
        idle(LAT + 3);
        rst_n   = 1'b0;
        bus.din = '0;
        expect_at(edge_cnt + 1, 16'h0000, 16'h0000, "rst_mid");
        expect_at(edge_cnt + 2, 16'h0000, 16'h0000, "rst_mid2");
        idle(2);
        rst_n = 1'b1;
        for (int i = 1; i <= LAT + 3; i++) expect_at(edge_cnt + i, 16'h0000, 16'h0000, "rst_after");
        idle(LAT + 4);

        idle(4);
        while (sbq.size() > 0) begin
            errors++;
            $display("FAIL %s: expectation for edge %0d left pending", sbq[0].name, sbq[0].due);
            void'(sbq.pop_front());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
